proc_sequencer: RTL and testbench

- Automated initiator that drives the 8-bit logic processor's LoadA/LoadB/Execute/Din interface in place of the push-buttons and switches.
- Accepts an operand pair plus a start strobe and replays the button sequence with pulse lengths safe for the processor's 2-flop input synchronizers.
- Reads back Aval/Bval once the operation completes and reports the result with a one-cycle done strobe.
- Sits between a host/test driver and the Processor top level, enabling scripted multi-operation runs and self-checking benches.

---
 rtl/proc_sequencer.sv | 139 +++++++++++++
 tb/tb_proc_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/proc_sequencer.sv
// Scripted driver for the 8-bit logic processor: replays LoadA/LoadB/Execute
// with synchronizer-safe pulse widths, then captures Aval/Bval with a done strobe.
module proc_sequencer #(
    parameter int unsigned PULSE_LEN  = 4,
    parameter int unsigned EXEC_LEN   = 16,
    parameter int unsigned SETTLE_LEN = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic [1:0] load_mask,
    input  logic [7:0] Aval,
    input  logic [7:0] Bval,
    output logic [7:0] din,
    output logic       ld_a,
    output logic       ld_b,
    output logic       exec,
    output logic       busy,
    output logic       done,
    output logic [7:0] res_a,
    output logic [7:0] res_b
);

    typedef enum logic [2:0] {
        S_IDLE, S_LDA, S_GAPA, S_LDB, S_GAPB, S_EXEC, S_SETTLE, S_DONE
    } state_t;

    localparam logic [7:0] C_PULSE  = 8'(PULSE_LEN - 1);
    localparam logic [7:0] C_EXEC   = 8'(EXEC_LEN - 1);
    localparam logic [7:0] C_SETTLE = 8'(SETTLE_LEN - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_op_b;
    logic       r_load_b;
    logic [7:0] r_din;
    logic       r_ld_a, r_ld_b, r_exec, r_busy, r_done;
    logic [7:0] r_res_a, r_res_b;

    state_t     w_next;
    logic [7:0] w_cnt_next;
    logic [7:0] w_din_next;
    logic       w_cnt_zero;
    logic       w_capture;

    function automatic logic [7:0] entry_count(input state_t s);
        case (s)
            S_LDA, S_GAPA, S_LDB, S_GAPB: entry_count = C_PULSE;
            S_EXEC:                       entry_count = C_EXEC;
            S_SETTLE:                     entry_count = C_SETTLE;
            default:                      entry_count = '0;
        endcase
    endfunction

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (load_mask[0])      w_next = S_LDA;
                    else if (load_mask[1]) w_next = S_LDB;
                    else                   w_next = S_EXEC;
                end
            end
            S_LDA:    if (w_cnt_zero) w_next = S_GAPA;
            S_GAPA:   if (w_cnt_zero) w_next = r_load_b ? S_LDB : S_EXEC;
            S_LDB:    if (w_cnt_zero) w_next = S_GAPB;
            S_GAPB:   if (w_cnt_zero) w_next = S_EXEC;
            S_EXEC:   if (w_cnt_zero) w_next = S_SETTLE;
            S_SETTLE: if (w_cnt_zero) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Counter reloads on every state entry so each phase length is independent.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next != r_state)  w_cnt_next = entry_count(w_next);
        else if (!w_cnt_zero)   w_cnt_next = r_cnt - 8'd1;
    end

    // LDA is only entered from IDLE; LDB may be entered from IDLE or GAPA.
    always_comb begin
        w_din_next = r_din;
        if (w_next == S_LDA && r_state == S_IDLE) w_din_next = op_a;
        else if (w_next == S_LDB && r_state == S_IDLE) w_din_next = op_b;
        else if (w_next == S_LDB && r_state == S_GAPA) w_din_next = r_op_b;
    end

    assign w_capture = (r_state == S_SETTLE) && (w_next == S_DONE);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_b   <= '0;
            r_load_b <= 1'b0;
            r_din    <= '0;
            r_ld_a   <= 1'b0;
            r_ld_b   <= 1'b0;
            r_exec   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_res_a  <= '0;
            r_res_b  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_din   <= w_din_next;
            if (r_state == S_IDLE && start) begin
                r_op_b   <= op_b;
                r_load_b <= load_mask[1];
            end
            r_ld_a <= (w_next == S_LDA);
            r_ld_b <= (w_next == S_LDB);
            r_exec <= (w_next == S_EXEC);
            r_busy <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done <= (w_next == S_DONE);
            if (w_capture) begin
                r_res_a <= Aval;
                r_res_b <= Bval;
            end
        end
    end

    assign din   = r_din;
    assign ld_a  = r_ld_a;
    assign ld_b  = r_ld_b;
    assign exec  = r_exec;
    assign busy  = r_busy;
    assign done  = r_done;
    assign res_a = r_res_a;
    assign res_b = r_res_b;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: XOR-processor stub, timeline reference model, directed and random runs.
module tb_proc_sequencer;

    localparam int unsigned P = 4;
    localparam int unsigned E = 16;
    localparam int unsigned S = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op_a = '0, op_b = '0;
    logic [1:0] load_mask = '0;
    logic [7:0] Aval, Bval;
    logic [7:0] din, res_a, res_b;
    logic       ld_a, ld_b, exec, busy, done;

    int checks = 0;
    int failures = 0;

    proc_sequencer #(.PULSE_LEN(P), .EXEC_LEN(E), .SETTLE_LEN(S)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .op_a(op_a), .op_b(op_b),
        .load_mask(load_mask), .Aval(Aval), .Bval(Bval), .din(din),
        .ld_a(ld_a), .ld_b(ld_b), .exec(exec), .busy(busy), .done(done),
        .res_a(res_a), .res_b(res_b)
    );

    always #5 Clk = ~Clk;

    // Processor stub: loads on ld pulses, A <= A ^ B once per execute pulse.
    logic [7:0] pA = '0, pB = '0;
    logic       p_exec_d = 1'b0;
    always @(posedge Clk) begin
        if (ld_a) pA <= din;
        if (ld_b) pB <= din;
        if (exec && !p_exec_d) pA <= pA ^ pB;
        p_exec_d <= exec;
    end
    assign Aval = pA;
    assign Bval = pB;

    // Reference model: a sequence is a timeline offset t = 1..L after the accepting edge.
    bit         m_valid = 0;
    bit         m_active = 0;
    int         m_t = 0, m_da = 0, m_db = 0, m_len = 0;
    logic [7:0] m_opa = '0, m_opb = '0, m_din = '0, m_ra = '0, m_rb = '0;

    always @(posedge Clk) begin
        m_valid = 1;
        if (!Reset) begin
            m_active = 0; m_t = 0; m_din = '0; m_ra = '0; m_rb = '0;
        end else if (m_active) begin
            if (m_t == m_len) m_active = 0;
            else begin
                m_t++;
                if (m_t == m_len) begin m_ra = Aval; m_rb = Bval; end
            end
        end else if (start) begin
            m_active = 1; m_t = 1;
            m_opa = op_a; m_opb = op_b;
            m_da = load_mask[0] ? 2 * P : 0;
            m_db = load_mask[1] ? 2 * P : 0;
            m_len = m_da + m_db + E + S + 1;
        end
        if (m_active && m_t <= m_da) m_din = m_opa;
        else if (m_active && m_t <= m_da + m_db) m_din = m_opb;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    logic prev_done = 1'b0;
    always @(negedge Clk) begin
        if (m_valid) begin
            logic [28:0] got, exp;
            logic e_la, e_lb, e_ex, e_busy, e_done;
            e_la   = m_active && m_da != 0 && m_t <= P;
            e_lb   = m_active && m_db != 0 && m_t > m_da && m_t <= m_da + P;
            e_ex   = m_active && m_t > m_da + m_db && m_t <= m_da + m_db + E;
            e_busy = m_active && m_t < m_len;
            e_done = m_active && m_t == m_len;
            got = {din, ld_a, ld_b, exec, busy, done, res_a, res_b};
            exp = {m_din, e_la, e_lb, e_ex, e_busy, e_done, m_ra, m_rb};
            chk("outputs_vs_model", 32'(got), 32'(exp));
            chk("pulses_exclusive", 32'((ld_a && ld_b) || (ld_a && exec) || (ld_b && exec)), 32'd0);
            chk("busy_done_overlap", 32'(busy && done), 32'd0);
            chk("done_single_cycle", 32'(done && prev_done), 32'd0);
            prev_done = done;
        end
    end

    // Starts one operation from idle and pins its timing and results to literal values.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                          input int exp_n, input int exp_la, input int exp_lb, input int exp_ex,
                          input logic [7:0] exp_ra, input logic [7:0] exp_rb);
        int n, la, lb, ex;
        @(negedge Clk);
        op_a = a; op_b = b; load_mask = m; start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        n = 1; la = 0; lb = 0; ex = 0;
        while (!done && n < 200) begin
            la += int'(ld_a); lb += int'(ld_b); ex += int'(exec);
            if (ld_a) chk("din_during_ld_a", 32'(din), 32'(a));
            if (ld_b) chk("din_during_ld_b", 32'(din), 32'(b));
            @(negedge Clk);
            n++;
        end
        chk("done_offset", 32'(n), 32'(exp_n));
        chk("ld_a_cycles", 32'(la), 32'(exp_la));
        chk("ld_b_cycles", 32'(lb), 32'(exp_lb));
        chk("exec_cycles", 32'(ex), 32'(exp_ex));
        chk("res_a", 32'(res_a), 32'(exp_ra));
        chk("res_b", 32'(res_b), 32'(exp_rb));
    endtask

    initial begin
        int n, dones;
        repeat (3) @(negedge Clk);
        chk("reset_outputs", 32'({din, ld_a, ld_b, exec, busy, done, res_a, res_b}), 32'd0);
        Reset = 1'b1;

        run_op(8'h3C, 8'hA5, 2'b11, 37, 4, 4, 16, 8'h99, 8'hA5);
        run_op(8'h00, 8'hA5, 2'b00, 21, 0, 0, 16, 8'h3C, 8'hA5);
        run_op(8'h0F, 8'h00, 2'b11, 37, 4, 4, 16, 8'h0F, 8'h00);
        run_op(8'h55, 8'hFF, 2'b10, 29, 0, 4, 16, 8'hF0, 8'hFF);

        // Reset asserted for 3 cycles in the middle of EXEC.
        @(negedge Clk);
        op_a = 8'h11; op_b = 8'h22; load_mask = 2'b11; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        n = 0;
        while (!exec && n < 100) begin @(negedge Clk); n++; end
        chk("exec_reached", 32'(exec), 32'd1);
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("mid_exec_reset_outputs", 32'({din, ld_a, ld_b, exec, busy, done, res_a, res_b}), 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        run_op(8'h11, 8'h22, 2'b11, 37, 4, 4, 16, 8'h33, 8'h22);

        // start held high: back-to-back runs, two completions in the first 100 cycles.
        @(negedge Clk);
        op_a = 8'h5A; op_b = 8'h3C; load_mask = 2'b11; start = 1'b1;
        @(posedge Clk);
        dones = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge Clk);
            dones += int'(done);
        end
        chk("held_start_dones", 32'(dones), 32'd2);
        start = 1'b0;
        n = 0;
        while ((busy || done) && n < 200) begin @(negedge Clk); n++; end
        chk("drain_idle", 32'(busy || done), 32'd0);

        // Random operations, stray starts and occasional resets.
        for (int it = 0; it < 40; it++) begin
            @(negedge Clk);
            op_a = 8'($urandom); op_b = 8'($urandom); load_mask = 2'($urandom);
            start = 1'b1;
            @(negedge Clk);
            start = 1'b0;
            for (int c = 0; c < int'($urandom_range(60, 5)); c++) begin
                @(negedge Clk);
                start = ($urandom_range(9, 0) == 0);
                op_a = 8'($urandom); op_b = 8'($urandom); load_mask = 2'($urandom);
                Reset = ($urandom_range(99, 0) != 0);
            end
            start = 1'b0;
            Reset = 1'b1;
        end
        repeat (60) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
